// File: rtl/bsg_counter_underflow_reload_en.sv
// Enabled down-counter; on reaching zero it reloads from a one-entry shadow register, refilled via valid/ready.
// Latency: count_o registered, underflow_o/reload_ready_o combinational. Backpressure: ready drops while a value is pending, until the next underflow.
module bsg_counter_underflow_reload_en #(
  parameter int max_val_p  = 1000000,
  parameter int init_val_p = 999999,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                reload_v_i,
  input  logic [width_lp-1:0] reload_i,
  output logic                reload_ready_o,
  output logic [width_lp-1:0] count_o,
  output logic                underflow_o,
  output logic                reload_pending_o
);

  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);
  localparam logic [width_lp-1:0] one_lp  = width_lp'(1);

  if (init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must not exceed max_val_p");
  end

  logic [width_lp-1:0] count_q, count_d;
  logic [width_lp-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                underflow;
  logic                ready;
  logic                handshake;
  logic [width_lp-1:0] reload_clamped;

  always_comb begin
    underflow      = (count_q == '0);
    ready          = reset_i & (~pending_q | underflow);
    handshake      = reload_v_i & ready;
    reload_clamped = (reload_i > max_lp) ? max_lp : reload_i;

    count_d   = count_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (underflow) begin
      // A value offered in the underflow cycle bypasses the shadow straight into the count.
      if (handshake) begin
        count_d  = reload_clamped;
        shadow_d = reload_clamped;
      end else begin
        count_d  = shadow_q;
      end
      pending_d = 1'b0;
    end else begin
      if (en_i) begin
        count_d = count_q - one_lp;
      end
      if (handshake) begin
        shadow_d  = reload_clamped;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q   <= init_lp;
      shadow_q  <= init_lp;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign count_o          = count_q;
  assign underflow_o      = underflow;
  assign reload_ready_o   = ready;
  assign reload_pending_o = pending_q;

endmodule

// File: tb/tb_bsg_counter_underflow_reload_en.sv
// Directed and randomized checks of the reload down-counter against an integer reference model.
module tb_bsg_counter_underflow_reload_en;

  localparam int MAX  = 10;
  localparam int INIT = 3;
  localparam int W    = $clog2(MAX + 1);

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic         reload_v_i;
  logic [W-1:0] reload_i;
  logic         reload_ready_o;
  logic [W-1:0] count_o;
  logic         underflow_o;
  logic         reload_pending_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_cnt;
  int m_sh;
  int m_pend;

  always #5 clk_i = ~clk_i;

  bsg_counter_underflow_reload_en #(.max_val_p(MAX), .init_val_p(INIT)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .en_i            (en_i),
    .reload_v_i      (reload_v_i),
    .reload_i        (reload_i),
    .reload_ready_o  (reload_ready_o),
    .count_o         (count_o),
    .underflow_o     (underflow_o),
    .reload_pending_o(reload_pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, advance model on the edge.
  task automatic cyc(input logic rst, input logic en, input logic v, input int val, output logic acc);
    logic m_uf, m_rdy;
    int   r;
    reset_i = rst; en_i = en; reload_v_i = v; reload_i = W'(val);
    #2;
    m_uf  = (m_cnt == 0);
    m_rdy = rst && (!m_pend || m_uf);
    chk("count", count_o, m_cnt);
    chk("underflow", underflow_o, int'(m_uf));
    chk("ready", reload_ready_o, int'(m_rdy));
    chk("pending", reload_pending_o, m_pend);
    acc = v && m_rdy;
    @(posedge clk_i);
    r = (val > MAX) ? MAX : val;
    if (!rst) begin
      m_cnt = INIT; m_sh = INIT; m_pend = 0;
    end else if (m_uf) begin
      m_cnt = acc ? r : m_sh;
      if (acc) m_sh = r;
      m_pend = 0;
    end else begin
      if (acc) begin m_sh = r; m_pend = 1; end
      if (en) m_cnt = m_cnt - 1;
    end
    #1;
  endtask

  task automatic go(input logic en);
    logic acc;
    cyc(1'b1, en, 1'b0, 0, acc);
  endtask

  task automatic run_to_zero();
    for (int k = 0; k < 40 && m_cnt != 0; k++) go(1'b1);
    chk("reach_zero", count_o, 0);
  endtask

  int   seq1[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
  logic en2[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   seq2[6] = '{3, 2, 2, 1, 1, 0};

  initial begin
    logic acc;
    logic offer_v;
    int   offer_val;

    // Unchecked reset edge to get out of X.
    reset_i = 1'b0; en_i = 1'b0; reload_v_i = 1'b0; reload_i = '0;
    @(posedge clk_i); #1;
    m_cnt = INIT; m_sh = INIT; m_pend = 0;

    // Held in reset with an offer present: no handshake.
    cyc(1'b0, 1'b1, 1'b1, 5, acc);
    chk("rst_no_accept", acc, 0);
    chk("rst_count", count_o, 3);

    // Free-running count.
    for (int i = 0; i < 8; i++) begin
      chk("seq_en", count_o, seq1[i]);
      go(1'b1);
    end

    // Toggled enable; reload at zero ignores en_i.
    for (int i = 0; i < 6; i++) begin
      chk("seq_toggle", count_o, seq2[i]);
      go(en2[i]);
    end
    chk("reload_no_en", count_o, 3);

    // Reload 7 accepted at count 2, applied at the next underflow.
    go(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 7, acc);
    chk("acc7", acc, 1);
    chk("pend7", reload_pending_o, 1);
    run_to_zero();
    go(1'b1);
    chk("applied7", count_o, 7);
    for (int i = 0; i < 8; i++) go(1'b1);
    chk("period8", count_o, 7);

    // Pending value plus a stalled second offer that bypasses at underflow.
    cyc(1'b1, 1'b1, 1'b1, 4, acc);
    chk("acc4", acc, 1);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cyc(1'b1, 1'b1, 1'b1, 5, acc);
    chk("acc5", acc, 1);
    chk("bypass5", count_o, 5);
    chk("bypass_pend", reload_pending_o, 0);

    // Clamp above max.
    cyc(1'b1, 1'b1, 1'b1, 15, acc);
    chk("acc15", acc, 1);
    run_to_zero();
    go(1'b1);
    chk("clamp10", count_o, 10);

    // Reload 0 sticks at zero until a nonzero reload arrives.
    cyc(1'b1, 1'b1, 1'b1, 0, acc);
    run_to_zero();
    go(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("zero_uf", underflow_o, 1);
      go(1'b1);
    end
    cyc(1'b1, 1'b1, 1'b1, 4, acc);
    chk("acc4b", acc, 1);
    chk("after_zero4", count_o, 4);

    // Reset with a reload pending discards it.
    cyc(1'b1, 1'b1, 1'b1, 6, acc);
    go(1'b1);
    go(1'b1);
    chk("pre_rst_count", count_o, 1);
    chk("pre_rst_pend", reload_pending_o, 1);
    cyc(1'b0, 1'b1, 1'b0, 0, acc);
    chk("post_rst_count", count_o, 3);
    chk("post_rst_pend", reload_pending_o, 0);
    run_to_zero();
    go(1'b1);
    chk("post_rst_reload", count_o, 3);

    // Randomized traffic with a protocol-abiding offerer.
    offer_v = 1'b0; offer_val = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!offer_v && $urandom_range(7) == 0) begin
        offer_v   = 1'b1;
        offer_val = int'($urandom_range(15));
      end
      cyc(($urandom_range(49) != 0), ($urandom_range(3) != 0), offer_v, offer_val, acc);
      if (acc) offer_v = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
